// File: rtl/exec_flag_stage_pkg.sv
// Shared CPU definitions for the execute/writeback slice:
// ALU op encodings, ARM condition encodings, NZCV bit positions
// and the flag-merge helper used when an instruction sets flags.
package exec_flag_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_AND = 4'd1,
    ALU_XOR = 4'd2,
    ALU_OR  = 4'd3
  } alu_ctrl_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Arithmetic ops replace all four flags; every other op (including
  // unassigned encodings) only updates N and Z, keeping C and V.
  function automatic logic [3:0] next_flags(input logic [3:0] cur,
                                            input logic [3:0] alu_nzcv,
                                            input logic [3:0] alu_ctrl);
    logic [3:0] res;
    res = cur;
    if (alu_ctrl == ALU_ADD) begin
      res = alu_nzcv;
    end else begin
      res[FLAG_N] = alu_nzcv[FLAG_N];
      res[FLAG_Z] = alu_nzcv[FLAG_Z];
    end
    return res;
  endfunction

endpackage

// File: rtl/exec_flag_stage_cond_check.sv
// ARM condition-code evaluator: purely combinational, COND + NZCV -> pass.
// Kept standalone so branch logic can reuse the same decode.
module cond_check
  import exec_flag_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Decode the condition field against the current flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_flag_stage.sv
// Execute-to-writeback stage: registers ALU results into writeback
// packets through a 2-entry skid buffer (so in_ready is a flop and
// writeback stalls never reach the ALU combinationally), and owns the
// architectural NZCV register used for conditional execution.
module exec_flag_stage
  import exec_flag_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_out,
  input  logic [3:0]    alu_nzcv,
  input  logic [3:0]    alu_ctrl,
  input  logic [3:0]    cond,
  input  logic          s_bit,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_we,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] wb_data,
  output logic [AW-1:0] wb_addr,
  output logic          wb_en,
  output logic          cond_pass,
  output logic [3:0]    flags
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          en;
    logic          pass;
  } pkt_t;

  logic       pass_s;
  logic       accept_s;
  pkt_t       in_pkt_s;
  pkt_t       out_pkt_r;
  pkt_t       skid_pkt_r;
  logic       out_valid_r;
  logic       skid_valid_r;
  logic       in_ready_r;
  logic [3:0] flags_r;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_r),
    .pass  (pass_s)
  );

  // A flushed beat is never accepted, so it can neither enter the
  // buffer nor touch the flags.
  assign accept_s = in_valid & in_ready_r & ~flush;

  // Build the packet for the incoming beat; a failed condition kills the write.
  always_comb begin
    in_pkt_s      = '0;
    in_pkt_s.data = alu_out;
    in_pkt_s.addr = rd_addr;
    in_pkt_s.en   = rd_we & pass_s;
    in_pkt_s.pass = pass_s;
  end

  // Output entry plus skid entry; in_ready tracks the next skid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pkt_r    <= '0;
      skid_pkt_r   <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else if (!out_valid_r || out_ready) begin
      // Output entry is free or draining: refill oldest-first.
      if (skid_valid_r) begin
        out_pkt_r    <= skid_pkt_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
      end else if (accept_s) begin
        out_pkt_r    <= in_pkt_s;
        out_valid_r  <= 1'b1;
        in_ready_r   <= 1'b1;
      end else begin
        out_valid_r  <= 1'b0;
        in_ready_r   <= 1'b1;
      end
    end else if (accept_s) begin
      // Output stalled: park the beat and stop accepting.
      skid_pkt_r   <= in_pkt_s;
      skid_valid_r <= 1'b1;
      in_ready_r   <= 1'b0;
    end else begin
      in_ready_r   <= ~skid_valid_r;
    end
  end

  // Architectural NZCV: committed only by accepted, passing, flag-setting beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (accept_s && pass_s && s_bit) begin
      flags_r <= next_flags(flags_r, alu_nzcv, alu_ctrl);
    end else begin
      flags_r <= flags_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign wb_data   = out_pkt_r.data;
  assign wb_addr   = out_pkt_r.addr;
  assign wb_en     = out_pkt_r.en;
  assign cond_pass = out_pkt_r.pass;
  assign flags     = flags_r;

endmodule

// File: tb/tb_exec_flag_stage.sv
// Scoreboard bench for exec_flag_stage: the driver pushes the expected
// writeback packet when a beat is accepted, an independent monitor pops
// and compares whenever a packet is handed off on the output.
module tb_exec_flag_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [3:0]  alu_nzcv;
  logic [3:0]  alu_ctrl;
  logic [3:0]  cond;
  logic        s_bit;
  logic [3:0]  rd_addr;
  logic        rd_we;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_addr;
  logic        wb_en;
  logic        cond_pass;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  addr;
    logic        en;
    logic        pass;
  } exp_t;

  exp_t       sb_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_flags = 4'b0000;

  exec_flag_stage #(.DW(32), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_nzcv  (alu_nzcv),
    .alu_ctrl  (alu_ctrl),
    .cond      (cond),
    .s_bit     (s_bit),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_data   (wb_data),
    .wb_addr   (wb_addr),
    .wb_en     (wb_en),
    .cond_pass (cond_pass),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference condition evaluation in ARM pair form: even code = base test,
  // odd code = its inverse; 1111 never passes.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~b : b;
  endfunction

  // Present a beat, wait (bounded) for in_ready, record the expectation.
  task automatic send(input logic [31:0] d, input logic [3:0] nz, input logic [3:0] ctrl,
                      input logic [3:0] c, input logic s, input logic [3:0] a, input logic we);
    int   n;
    logic p;
    exp_t e;
    alu_out = d; alu_nzcv = nz; alu_ctrl = ctrl; cond = c;
    s_bit = s; rd_addr = a; rd_we = we; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
      in_valid = 1'b0;
    end else begin
      p = ref_pass(c, exp_flags);
      e.data = d; e.addr = a; e.en = we & p; e.pass = p;
      sb_q.push_back(e);
      if (p && s) begin
        if (ctrl == 4'd0) exp_flags = nz;
        else exp_flags[3:2] = nz[3:2];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Monitor: every handed-off packet must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_out: got packet data %0h, expected none", wb_data);
      end else begin
        e = sb_q.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_addr", {28'd0, wb_addr}, {28'd0, e.addr});
        chk("wb_en", {31'd0, wb_en}, {31'd0, e.en});
        chk("cond_pass", {31'd0, cond_pass}, {31'd0, e.pass});
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_out = 32'd0; alu_nzcv = 4'd0; alu_ctrl = 4'd0;
    cond = 4'd14; s_bit = 1'b0; rd_addr = 4'd0; rd_we = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: simple AL beat
    out_ready = 1'b1;
    send(32'h5, 4'b0000, 4'd0, 4'd14, 1'b0, 4'd3, 1'b1);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_wb_en", {31'd0, wb_en}, 32'd1);
    chk("t1_flags", {28'd0, flags}, 32'd0);

    // 2: ADD sets all flags, AND keeps C/V
    send(32'h10, 4'b0110, 4'd0, 4'd14, 1'b1, 4'd1, 1'b1);
    chk("t2_flags_add", {28'd0, flags}, 32'h6);
    send(32'h11, 4'b1000, 4'd1, 4'd14, 1'b1, 4'd2, 1'b1);
    chk("t2_flags_and", {28'd0, flags}, 32'hA);

    // 3: failed condition kills write and flag update
    send(32'h20, 4'b0100, 4'd0, 4'd14, 1'b1, 4'd4, 1'b1);
    send(32'h21, 4'b1001, 4'd0, 4'd1, 1'b1, 4'd5, 1'b1);
    chk("t3_ne_wb_en", {31'd0, wb_en}, 32'd0);
    chk("t3_ne_pass", {31'd0, cond_pass}, 32'd0);
    chk("t3_flags_kept", {28'd0, flags}, 32'h4);
    send(32'h22, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd6, 1'b1);
    chk("t3_eq_wb_en", {31'd0, wb_en}, 32'd1);

    // 4: back-pressure through the skid entry
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'hD1, 4'b0000, 4'd2, 4'd14, 1'b0, 4'd7, 1'b1);
    send(32'hD2, 4'b0000, 4'd2, 4'd14, 1'b0, 4'd8, 1'b1);
    chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
    alu_out = 32'hD3; rd_addr = 4'd9; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("t4_in_ready_held", {31'd0, in_ready}, 32'd0);
      chk("t4_hold_data", wb_data, 32'hD1);
    end
    out_ready = 1'b1;
    send(32'hD3, 4'b0000, 4'd2, 4'd14, 1'b0, 4'd9, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("t4_drained", sb_q.size(), 32'd0);

    // 5: flush with a full skid buffer
    out_ready = 1'b0;
    send(32'hD4, 4'b0000, 4'd0, 4'd14, 1'b0, 4'd10, 1'b1);
    send(32'hD5, 4'b0000, 4'd0, 4'd14, 1'b0, 4'd11, 1'b1);
    chk("t5_skid_full", {31'd0, in_ready}, 32'd0);
    alu_out = 32'hDEAD; alu_nzcv = 4'b1111; alu_ctrl = 4'd0; cond = 4'd14; s_bit = 1'b1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_flags", {28'd0, flags}, 32'h4);
    sb_q.delete();
    out_ready = 1'b1;

    // 6: every condition against every flag value
    for (int f = 0; f < 16; f++) begin
      send(32'(f), 4'(f), 4'd0, 4'd14, 1'b1, 4'd12, 1'b1);
      chk("t6_flags", {28'd0, flags}, 32'(f));
      for (int c = 0; c < 16; c++) begin
        send(32'h100 + 32'(f * 16 + c), 4'b1111, 4'd2, 4'(c), 1'b0, 4'(c), 1'b1);
      end
    end
    repeat (3) @(posedge clk); #1;
    chk("t6_drained", sb_q.size(), 32'd0);

    // Reset in the middle of traffic clears outputs without a clock
    out_ready = 1'b0;
    send(32'hBEEF, 4'b1111, 4'd0, 4'd14, 1'b1, 4'd13, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wb_addr", {28'd0, wb_addr}, 32'd0);
    chk("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("mid_rst_cond_pass", {31'd0, cond_pass}, 32'd0);
    chk("mid_rst_flags", {28'd0, flags}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    exp_flags = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h5A, 4'b0000, 4'd0, 4'd0, 1'b0, 4'd2, 1'b1);
    send(32'h5B, 4'b0000, 4'd0, 4'd1, 1'b0, 4'd3, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("final_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_flag_stage.md
Name: exec_flag_stage

Overview:
- Execute-to-writeback stage sitting directly downstream of the ALU.
- Registers each ALU result into a writeback packet.
- Holds the architectural NZCV flag register (CPSR[31:28]) and evaluates the 4-bit ARM condition field against it.
- Uses a 2-entry skid buffer so IN_READY is a registered signal and writeback back-pressure never creates a combinational path back into the ALU.

Parameters:
- DW, 32, datapath width of ALU result / WB_DATA.
- AW, 4, register-file address width.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  ALU result beat valid.
- IN_READY  output  1  stage can accept a beat (registered).
- ALU_OUT  input  DW  ALU result.
- ALU_NZCV  input  4  flags produced by ALU: [3]=N, [2]=Z, [1]=C, [0]=V.
- ALU_CTRL  input  4  ALU op select: 0 ADD, 1 AND, 2 XOR, 3 OR.
- COND  input  4  ARM condition field of the instruction.
- S_BIT  input  1  instruction requests flag update.
- RD_ADDR  input  AW  destination register.
- RD_WE  input  1  instruction writes a register.
- FLUSH  input  1  synchronous pipeline flush.
- OUT_VALID  output  1  writeback packet valid.
- OUT_READY  input  1  writeback accepts packet.
- WB_DATA  output  DW  result to register file.
- WB_ADDR  output  AW  destination register.
- WB_EN  output  1  commit write (RD_WE AND condition passed).
- COND_PASS  output  1  condition result of the packet on OUT.
- FLAGS  output  4  architectural NZCV register.

Behaviour:
- Reset (RST_N low, async):
  - OUT_VALID=0, WB_DATA=0, WB_ADDR=0, WB_EN=0, COND_PASS=0, FLAGS=0.
  - Both buffer entries invalid; IN_READY=1.
- Accept condition: IN_VALID & IN_READY & !FLUSH.
- Condition evaluation: combinational at accept time, using the current FLAGS register.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V).
  - AL(1110) pass=1; 1111 pass=0 (never).
- Flag update on accept when pass & S_BIT:
  - ALU_CTRL=ADD: FLAGS <= ALU_NZCV (all four bits).
  - Logical ops (1/2/3): FLAGS[3:2] <= ALU_NZCV[3:2]; C and V are preserved.
  - ALU_CTRL values 4..15: treated as logical.
- FLAGS becomes visible the cycle after accept. A back-to-back next beat is evaluated against the updated FLAGS, so there is no hazard window.
- Failed-condition beats still flow to OUT with WB_EN=0 and COND_PASS=0, and never modify FLAGS.
- Latency: accepted beat appears on OUT the next cycle when the output entry is free or draining.
- Skid buffer: output entry (drives OUT) plus skid entry; IN_READY = !skid_valid (registered).
  - Accept while output entry valid & !OUT_READY: beat goes to skid entry; IN_READY drops the next cycle.
  - OUT_READY & output valid: skid (if valid) moves to output entry; otherwise the incoming beat does, otherwise output becomes invalid.
  - Simultaneous accept + drain with skid valid: impossible, since IN_READY=0.
  - Ordering is strictly FIFO.
- OUT signals are held stable while OUT_VALID & !OUT_READY.
- FLUSH (sync, priority over everything):
  - Both entries are invalidated the next cycle.
  - An incoming beat in the FLUSH cycle is discarded and does not update FLAGS.
  - FLAGS keeps already-committed values.
  - IN_READY=1 the cycle after FLUSH.
- Reset mid-operation: all in-flight beats are lost; FLAGS=0.
- Packet register width: DW+AW+2 (data, addr, we&pass, pass).

Decomposition:
- Shared package/header (cpu_defs): ALU_CTRL encodings (ALU_ADD=0, ALU_AND=1, ALU_XOR=2, ALU_OR=3), condition encodings EQ..NV, NZCV bit indices.
- One sub-module: cond_check (combinational, COND + FLAGS -> pass), reusable by branch logic.
- Skid buffer stays inline.

Test Plan:
1. Reset then IN_VALID with ALU_OUT=0x00000005, COND=AL, RD_WE=1, RD_ADDR=3, OUT_READY=1 -> next cycle OUT_VALID=1, WB_DATA=5, WB_ADDR=3, WB_EN=1, FLAGS stays 0.
2. ADD with S_BIT=1, ALU_NZCV=4'b0110, then AND with S_BIT=1, ALU_NZCV=4'b1000 -> FLAGS=0110, then 1010 (C kept, V kept at 0).
3. FLAGS Z=1; beat COND=NE, RD_WE=1, S_BIT=1 -> OUT packet WB_EN=0, COND_PASS=0, FLAGS unchanged. Next beat COND=EQ -> WB_EN=1.
4. Hold OUT_READY=0 and send 3 beats (D1, D2, D3) -> D1 held on OUT, D2 in skid, IN_READY=0 on cycle 3 so D3 waits. Release -> D1, D2, D3 in order with no loss or duplication.
5. Skid full, assert FLUSH with IN_VALID=1, S_BIT=1, ALU_NZCV=1111 -> next cycle OUT_VALID=0, IN_READY=1, FLAGS unchanged.
6. Cover all 16 COND values against all 16 FLAGS values; COND_PASS must match the condition table, 1111 always 0. Assert RST_N low mid-stream -> outputs zero immediately.
